mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates IFU fetch and LSU data requests onto one shared memory port; one transaction in flight.
// Latency: accept at N, mem request at N+1, response at N+2 at the earliest, next accept at N+3.
// Backpressure: requesters stall until *_ready_o (IDLE only); mem request held until mem_ready_i; response wait times out.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                ifu_valid_i,
    input  logic [ADDR_W-1:0]   ifu_addr_i,
    output logic                ifu_ready_o,
    output logic                ifu_rvalid_o,
    output logic                ifu_err_o,
    output logic [DATA_W-1:0]   ifu_rdata_o,
    input  logic                lsu_valid_i,
    input  logic                lsu_wen_i,
    input  logic [ADDR_W-1:0]   lsu_addr_i,
    input  logic [DATA_W-1:0]   lsu_wdata_i,
    input  logic [DATA_W/8-1:0] lsu_mask_i,
    output logic                lsu_ready_o,
    output logic                lsu_rvalid_o,
    output logic                lsu_err_o,
    output logic [DATA_W-1:0]   lsu_rdata_o,
    output logic                mem_valid_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic                mem_wen_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_mask_o,
    input  logic                mem_ready_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
);
    localparam int         MASK_W    = DATA_W / 8;
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic       OWN_IFU   = 1'b0;
    localparam logic       OWN_LSU   = 1'b1;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wen;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] mask;
    } req_t;

    state_t     state, state_nxt;
    req_t       req_q, req_d;
    logic       owner_q, last_grant_q;
    logic [7:0] wait_cnt_q;
    logic       grant_ifu, grant_lsu, timed_out;

    // Round-robin: on contention the requester not served last wins.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (state == IDLE) begin
            grant_ifu = ifu_valid_i & (~lsu_valid_i | (last_grant_q == OWN_LSU));
            grant_lsu = lsu_valid_i & ~grant_ifu;
        end
    end

    // A real response in the last wait cycle beats the timeout.
    assign timed_out = (state == RESP) & ~mem_rvalid_i & (wait_cnt_q == WAIT_LAST);

    always_comb begin
        req_d = req_q;
        if (grant_ifu) begin
            req_d = '{addr: ifu_addr_i, wen: 1'b0, wdata: '0, mask: '1};
        end else if (grant_lsu) begin
            req_d = '{addr: lsu_addr_i, wen: lsu_wen_i, wdata: lsu_wdata_i, mask: lsu_mask_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            req_q        <= '0;
            owner_q      <= OWN_IFU;
            last_grant_q <= OWN_LSU;
            wait_cnt_q   <= '0;
        end else begin
            state <= state_nxt;
            req_q <= req_d;
            if (grant_ifu | grant_lsu) begin
                owner_q      <= grant_lsu;
                last_grant_q <= grant_lsu;
            end
            if (state == RESP) wait_cnt_q <= wait_cnt_q + 8'd1;
            else               wait_cnt_q <= '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_ifu | grant_lsu)    state_nxt = REQ;
            REQ:     if (mem_ready_i)              state_nxt = RESP;
            RESP:    if (mem_rvalid_i | timed_out) state_nxt = IDLE;
            default:                               state_nxt = IDLE;
        endcase
    end

    // Everything is forced quiet while reset is held so an abandoned transaction never leaks out.
    always_comb begin
        ifu_ready_o  = rst_i & grant_ifu;
        lsu_ready_o  = rst_i & grant_lsu;
        mem_valid_o  = 1'b0;
        mem_addr_o   = '0;
        mem_wen_o    = 1'b0;
        mem_wdata_o  = '0;
        mem_mask_o   = '0;
        ifu_rvalid_o = 1'b0;
        ifu_err_o    = 1'b0;
        ifu_rdata_o  = '0;
        lsu_rvalid_o = 1'b0;
        lsu_err_o    = 1'b0;
        lsu_rdata_o  = '0;
        if (rst_i && state == REQ) begin
            mem_valid_o = 1'b1;
            mem_addr_o  = req_q.addr;
            mem_wen_o   = req_q.wen;
            mem_wdata_o = req_q.wdata;
            mem_mask_o  = req_q.mask;
        end
        if (rst_i && state == RESP) begin
            if (owner_q == OWN_IFU) begin
                ifu_rvalid_o = mem_rvalid_i | timed_out;
                ifu_err_o    = timed_out;
                ifu_rdata_o  = timed_out ? '0 : mem_rdata_i;
            end else begin
                lsu_rvalid_o = mem_rvalid_i | timed_out;
                lsu_err_o    = timed_out;
                lsu_rdata_o  = timed_out ? '0 : mem_rdata_i;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter: transaction-level model predicts grants, memory requests and responses.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;
    localparam int TO = 4;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic          rst_i;
    logic          ifu_valid_i;
    logic [AW-1:0] ifu_addr_i;
    logic          ifu_ready_o, ifu_rvalid_o, ifu_err_o;
    logic [DW-1:0] ifu_rdata_o;
    logic          lsu_valid_i, lsu_wen_i;
    logic [AW-1:0] lsu_addr_i;
    logic [DW-1:0] lsu_wdata_i;
    logic [MW-1:0] lsu_mask_i;
    logic          lsu_ready_o, lsu_rvalid_o, lsu_err_o;
    logic [DW-1:0] lsu_rdata_o;
    logic          mem_valid_o, mem_wen_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [MW-1:0] mem_mask_o;
    logic          mem_ready_i  = 1'b0;
    logic          mem_rvalid_i = 1'b0;
    logic [DW-1:0] mem_rdata_i  = '0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ifu_valid_i(ifu_valid_i), .ifu_addr_i(ifu_addr_i), .ifu_ready_o(ifu_ready_o),
        .ifu_rvalid_o(ifu_rvalid_o), .ifu_err_o(ifu_err_o), .ifu_rdata_o(ifu_rdata_o),
        .lsu_valid_i(lsu_valid_i), .lsu_wen_i(lsu_wen_i), .lsu_addr_i(lsu_addr_i),
        .lsu_wdata_i(lsu_wdata_i), .lsu_mask_i(lsu_mask_i), .lsu_ready_o(lsu_ready_o),
        .lsu_rvalid_o(lsu_rvalid_o), .lsu_err_o(lsu_err_o), .lsu_rdata_o(lsu_rdata_o),
        .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o), .mem_wen_o(mem_wen_o),
        .mem_wdata_o(mem_wdata_o), .mem_mask_o(mem_mask_o), .mem_ready_i(mem_ready_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    typedef struct {
        int            owner;
        logic [AW-1:0] addr;
        logic          wen;
        logic [DW-1:0] wdata;
        logic [MW-1:0] mask;
    } txn_t;

    typedef struct {
        int            owner;
        logic          err;
        logic [DW-1:0] data;
        int            due;
    } rsp_t;

    txn_t txn_q[$];
    int   hs_q[$];
    rsp_t rsp_q[$];
    int   grant_log[$];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Stimulus knobs, written only by the main sequence.
    int ifu_pct = 0, lsu_pct = 0, rdy_pct = 100, stray_pct = 0, fix_delay = -1;
    logic          fix_data_en = 1'b0;
    logic [DW-1:0] fix_data    = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: phase 0 = free, 1 = request to memory pending, 2 = awaiting response.
    int   phase = 0, cur_owner = 0, last_lsu = 1, g = 0, req_len = 0, last_req_len = 0;
    txn_t t;
    rsp_t r;

    always @(negedge clk_i) begin
        if (!rst_i) begin
            chk("reset_ctl", {ifu_ready_o, ifu_rvalid_o, ifu_err_o, lsu_ready_o, lsu_rvalid_o,
                              lsu_err_o, mem_valid_o, mem_wen_o, mem_mask_o}, 0);
            chk("reset_rdata", {ifu_rdata_o, lsu_rdata_o}, 0);
            chk("reset_mem", {mem_addr_o, mem_wdata_o}, 0);
            phase    = 0;
            last_lsu = 1;
            txn_q.delete();
            rsp_q.delete();
        end else begin
            if (phase == 1) begin
                t = txn_q[0];
                req_len++;
                chk("mem_valid", {63'd0, mem_valid_o}, 1);
                chk("mem_addr", {32'd0, mem_addr_o}, {32'd0, t.addr});
                chk("mem_ctl", {mem_wen_o, mem_mask_o}, {t.wen, t.mask});
                chk("mem_wdata", {32'd0, mem_wdata_o}, {32'd0, t.wdata});
                if (mem_ready_i) begin
                    hs_q.push_back(t.owner);
                    void'(txn_q.pop_front());
                    last_req_len = req_len;
                    phase = 2;
                end
            end else begin
                chk("mem_idle_ctl", {mem_valid_o, mem_wen_o, mem_mask_o}, 0);
                chk("mem_idle_data", {mem_addr_o, mem_wdata_o}, 0);
            end

            if (phase == 0 && (ifu_valid_i || lsu_valid_i)) begin
                g = (ifu_valid_i && (!lsu_valid_i || last_lsu == 1)) ? 0 : 1;
                chk("grant", {ifu_ready_o, lsu_ready_o}, (g == 0) ? 2'b10 : 2'b01);
                if (g == 0) t = '{0, ifu_addr_i, 1'b0, '0, '1};
                else        t = '{1, lsu_addr_i, lsu_wen_i, lsu_wdata_i, lsu_mask_i};
                txn_q.push_back(t);
                grant_log.push_back(g);
                last_lsu  = g;
                cur_owner = g;
                req_len   = 0;
                phase     = 1;
            end else begin
                chk("no_grant", {ifu_ready_o, lsu_ready_o}, 0);
            end

            if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
                r = rsp_q.pop_front();
                chk("ifu_rsp", {ifu_rvalid_o, ifu_err_o}, (r.owner == 0) ? {1'b1, r.err} : 2'b00);
                chk("ifu_rdata", {32'd0, ifu_rdata_o}, (r.owner == 0) ? {32'd0, r.data} : 64'd0);
                chk("lsu_rsp", {lsu_rvalid_o, lsu_err_o}, (r.owner == 1) ? {1'b1, r.err} : 2'b00);
                chk("lsu_rdata", {32'd0, lsu_rdata_o}, (r.owner == 1) ? {32'd0, r.data} : 64'd0);
                phase = 0;
            end else begin
                chk("no_rsp", {ifu_rvalid_o, ifu_err_o, lsu_rvalid_o, lsu_err_o}, 0);
                if (phase != 2) chk("idle_rdata", {ifu_rdata_o, lsu_rdata_o}, 0);
                else chk("nonowner_rdata", {32'd0, (cur_owner == 0) ? lsu_rdata_o : ifu_rdata_o}, 0);
            end
        end
    end

    // Memory responder: decides response delay/data at handshake and publishes the expected response.
    int            r_idx = -1, r_d = 0, r_owner = 0;
    logic [DW-1:0] r_data = '0;

    always @(posedge clk_i) begin
        #2;
        if (!rst_i) begin
            hs_q.delete();
            r_idx        = -1;
            mem_ready_i  = 1'b0;
            mem_rvalid_i = 1'b0;
        end else begin
            if (hs_q.size() > 0) begin
                r_owner = hs_q.pop_front();
                r_idx   = 0;
                r_d     = (fix_delay >= 0) ? fix_delay : int'($urandom_range(0, TO + 1));
                r_data  = fix_data_en ? fix_data : $urandom;
                if (r_d <= TO - 1) rsp_q.push_back('{r_owner, 1'b0, r_data, cyc + r_d});
                else               rsp_q.push_back('{r_owner, 1'b1, '0, cyc + TO - 1});
            end
            mem_ready_i = ($urandom_range(0, 99) < rdy_pct);
            mem_rdata_i = $urandom;
            if (r_idx >= 0) begin
                mem_rvalid_i = (r_idx == r_d);
                if (mem_rvalid_i) mem_rdata_i = r_data;
                r_idx = (r_idx == r_d || r_idx == TO - 1) ? -1 : r_idx + 1;
            end else begin
                mem_rvalid_i = ($urandom_range(0, 99) < stray_pct);
            end
        end
    end

    task automatic run_cycles(input int n);
        logic ia, la;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            ia = ifu_ready_o;
            la = lsu_ready_o;
            @(posedge clk_i);
            #1;
            if (ia || !ifu_valid_i) begin
                ifu_valid_i = ($urandom_range(0, 99) < ifu_pct);
                ifu_addr_i  = $urandom;
            end
            if (la || !lsu_valid_i) begin
                lsu_valid_i = ($urandom_range(0, 99) < lsu_pct);
                lsu_wen_i   = $urandom_range(0, 1);
                lsu_addr_i  = $urandom;
                lsu_wdata_i = $urandom;
                lsu_mask_i  = MW'($urandom);
            end
        end
    endtask

    task automatic issue(input int who, input logic [AW-1:0] a, input logic w,
                         input logic [DW-1:0] wd, input logic [MW-1:0] m);
        int   k   = 0;
        logic acc = 1'b0;
        @(posedge clk_i);
        #1;
        if (who == 0) begin
            ifu_valid_i = 1'b1;
            ifu_addr_i  = a;
        end else begin
            lsu_valid_i = 1'b1;
            lsu_addr_i  = a;
            lsu_wen_i   = w;
            lsu_wdata_i = wd;
            lsu_mask_i  = m;
        end
        while (!acc && k < 200) begin
            @(negedge clk_i);
            acc = (who == 0) ? ifu_ready_o : lsu_ready_o;
            k++;
        end
        n_chk++;
        if (!acc) begin
            n_fail++;
            $display("FAIL accept_timeout: requester %0d not accepted within 200 cycles", who);
        end
        @(posedge clk_i);
        #1;
        ifu_valid_i = 1'b0;
        lsu_valid_i = 1'b0;
    endtask

    task automatic wait_phase(input int p);
        int k = 0;
        while (phase != p && k < 300) begin
            @(negedge clk_i);
            k++;
        end
        n_chk++;
        if (phase != p) begin
            n_fail++;
            $display("FAIL wait_phase: model phase %0d, required %0d", phase, p);
        end
    endtask

    task automatic drain();
        ifu_pct = 0;
        lsu_pct = 0;
        run_cycles(60);
        wait_phase(0);
        run_cycles(2);
    endtask

    initial begin
        rst_i       = 1'b0;
        ifu_valid_i = 1'b0;
        ifu_addr_i  = '0;
        lsu_valid_i = 1'b0;
        lsu_wen_i   = 1'b0;
        lsu_addr_i  = '0;
        lsu_wdata_i = '0;
        lsu_mask_i  = '0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b1;

        // Minimum-latency IFU fetch.
        rdy_pct = 100; fix_delay = 0; fix_data_en = 1'b1; fix_data = 32'h0000_0413;
        issue(0, 32'h8000_0000, 1'b0, '0, '0);
        wait_phase(0);

        // Sustained contention must alternate.
        fix_data_en = 1'b0;
        grant_log.delete();
        ifu_pct = 100; lsu_pct = 100;
        run_cycles(30);
        chk("rr_grant_count_ok", {63'd0, grant_log.size() >= 6}, 1);
        for (int i = 1; i < grant_log.size(); i++)
            chk("rr_alternate", grant_log[i], (grant_log[i-1] == 0) ? 1 : 0);
        drain();

        // LSU write stalled by memory for three cycles.
        rdy_pct = 0; fix_delay = 1;
        issue(1, 32'h0000_0100, 1'b1, 32'hDEAD_BEEF, 4'h3);
        repeat (3) @(posedge clk_i);
        #1 rdy_pct = 100;
        wait_phase(0);
        chk("write_req_cycles", last_req_len, 4);

        // Timeout, and a response landing exactly on the timeout cycle.
        fix_delay = TO + 1;
        issue(0, 32'h0000_2000, 1'b0, '0, '0);
        wait_phase(0);
        fix_delay = TO - 1;
        issue(1, 32'h0000_3000, 1'b0, '0, 4'hF);
        wait_phase(0);

        // Reset while awaiting a response, late response afterwards, then contention.
        fix_delay = TO + 1;
        issue(1, 32'h0000_4000, 1'b1, 32'h1234_5678, 4'hC);
        wait_phase(2);
        @(posedge clk_i);
        #1 rst_i = 1'b0; stray_pct = 100;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
        grant_log.delete();
        fix_delay = -1; ifu_pct = 100; lsu_pct = 100;
        run_cycles(12);
        chk("post_reset_has_grant", {63'd0, grant_log.size() > 0}, 1);
        if (grant_log.size() > 0) chk("post_reset_first_grant", grant_log[0], 0);
        drain();

        // Randomised traffic with stray memory responses.
        ifu_pct = 40; lsu_pct = 40; rdy_pct = 60; stray_pct = 20; fix_delay = -1;
        run_cycles(2000);
        stray_pct = 0;
        drain();
        chk("queues_drained", txn_q.size() + hs_q.size() + rsp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
